// File: rtl/op_pkg.sv
// Shared front-end types: instruction/opcode definitions, the fetch queue entry
// layout and the istable pre-decode function used by fetch and decode.
// Ports: none (package).
package op_pkg;

    localparam int INSTRUCTION_WIDTH  = 32;
    localparam int SUPER_SCALAR_WIDTH = 2;
    localparam int DEQ_CNT_WIDTH      = $clog2(SUPER_SCALAR_WIDTH + 1);
    // Widest PC any queue instance may carry; narrower PCs are zero-extended.
    localparam int FETCH_PC_WIDTH     = 64;
    localparam int OPCODE_WIDTH       = 3;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OPCODE_UNKNOWN = 3'd0,
        OPCODE_ADD     = 3'd1,
        OPCODE_SUB     = 3'd2,
        OPCODE_B       = 3'd3,
        OPCODE_BL      = 3'd4,
        OPCODE_NOP     = 3'd5
    } opcode_t;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] instr;
        logic [FETCH_PC_WIDTH-1:0]    pc;
    } fetch_entry_t;

    // Coarse class of an A64 encoding. ADD/SUB are the non-flag-setting
    // immediate forms (bits 28:23 = 100010, S = 0); bit 30 picks SUB.
    function automatic opcode_t istable(input logic [INSTRUCTION_WIDTH-1:0] instr);
        opcode_t op;
        op = OPCODE_UNKNOWN;
        if (instr[28:23] == 6'b100010 && !instr[29]) begin
            op = instr[30] ? OPCODE_SUB : OPCODE_ADD;
        end else if (instr[31:26] == 6'b000101) begin
            op = OPCODE_B;
        end else if (instr[31:26] == 6'b100101) begin
            op = OPCODE_BL;
        end else if (instr == 32'hD503_201F) begin
            op = OPCODE_NOP;
        end
        return op;
    endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational per-lane opcode tagging of a group of instructions via istable.
// Ports: instr_in (W lanes x 32, lane 0 in the low bits), opcode_out (W lanes
// of opcode_t, same lane order). No state; shared with the decode stage.
module fetch_predecode
    import op_pkg::*;
(
    input  logic [SUPER_SCALAR_WIDTH*INSTRUCTION_WIDTH-1:0] instr_in,
    output logic [SUPER_SCALAR_WIDTH*OPCODE_WIDTH-1:0]      opcode_out
);

    for (genvar i = 0; i < SUPER_SCALAR_WIDTH; i++) begin : g_lane
        assign opcode_out[i*OPCODE_WIDTH +: OPCODE_WIDTH] =
            istable(instr_in[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH]);
    end

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode; presents the oldest
// W entries (combinational read, one-cycle enqueue-to-dequeue latency).
// Ports: clk_in/rst_in (sync, active-high), flush_in; enq_* group from fetch
// with enq_ready_out (registered-count based); deq_* head window with
// pre-decoded opcodes, deq_count_in consumption; count_out occupancy.
module fetch_queue
    import op_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PC_WIDTH = 64
) (
    input  logic                                            clk_in,
    input  logic                                            rst_in,
    input  logic                                            flush_in,
    input  logic [SUPER_SCALAR_WIDTH-1:0]                   enq_valid_in,
    input  logic [SUPER_SCALAR_WIDTH*INSTRUCTION_WIDTH-1:0] enq_instr_in,
    input  logic [SUPER_SCALAR_WIDTH*PC_WIDTH-1:0]          enq_pc_in,
    output logic                                            enq_ready_out,
    output logic [SUPER_SCALAR_WIDTH-1:0]                   deq_valid_out,
    output logic [SUPER_SCALAR_WIDTH*INSTRUCTION_WIDTH-1:0] deq_instr_out,
    output logic [SUPER_SCALAR_WIDTH*PC_WIDTH-1:0]          deq_pc_out,
    output logic [SUPER_SCALAR_WIDTH*OPCODE_WIDTH-1:0]      deq_opcode_out,
    input  logic [DEQ_CNT_WIDTH-1:0]                        deq_count_in,
    output logic [$clog2(DEPTH+1)-1:0]                      count_out
);

    localparam int W     = SUPER_SCALAR_WIDTH;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    // Storage is deliberately not reset; validity comes from count_q alone.
    fetch_entry_t mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic [CW-1:0]    enq_pop, enq_n, deq_avail, deq_n;
    logic [W-1:0]     wr_en;
    logic [PTR_W-1:0] wr_idx [W];
    logic [PTR_W-1:0] rd_idx [W];

    always_comb begin
        enq_ready_out = (count_q <= CW'(DEPTH - W));

        enq_pop   = '0;
        deq_avail = '0;
        for (int i = 0; i < W; i++) begin
            deq_valid_out[i] = (count_q > CW'(i));
            if (enq_valid_in[i])  enq_pop   = enq_pop + CW'(1);
            if (deq_valid_out[i]) deq_avail = deq_avail + CW'(1);
            wr_en[i]  = enq_ready_out && enq_valid_in[i] && !flush_in && !rst_in;
            wr_idx[i] = tail_q + PTR_W'(i);
            rd_idx[i] = head_q + PTR_W'(i);
        end

        enq_n = enq_ready_out ? enq_pop : '0;
        // Over-consumption is illegal; clamp so pointers never pass the tail.
        deq_n = (CW'(deq_count_in) > deq_avail) ? deq_avail : CW'(deq_count_in);

        head_d  = head_q + PTR_W'(deq_n);
        tail_d  = tail_q + PTR_W'(enq_n);
        count_d = count_q + enq_n - deq_n;
        if (flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < W; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_idx[i]].instr <= enq_instr_in[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
                mem_q[wr_idx[i]].pc    <= FETCH_PC_WIDTH'(enq_pc_in[i*PC_WIDTH +: PC_WIDTH]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < W; i++) begin
            deq_instr_out[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = mem_q[rd_idx[i]].instr;
            deq_pc_out[i*PC_WIDTH +: PC_WIDTH] = mem_q[rd_idx[i]].pc[PC_WIDTH-1:0];
        end
    end

    assign count_out = count_q;

    fetch_predecode u_predecode (
        .instr_in   (deq_instr_out),
        .opcode_out (deq_opcode_out)
    );

    // Lane valids must form a contiguous run starting at lane 0.
    assert property (@(posedge clk_in) disable iff (rst_in)
        ((enq_valid_in + W'(1)) & enq_valid_in) == '0);

    // Decode may only consume presented entries.
    assert property (@(posedge clk_in) disable iff (rst_in)
        CW'(deq_count_in) <= deq_avail);

endmodule
